// File: rtl/pass_monitor_if.sv
// Handshake-free bundle between a serial bit source and pass_monitor.
// Source drives in/enable/clear; the monitor returns registered pulses and counter.
interface pass_monitor_if #(
  parameter int COUNT_WIDTH = 8
);
  logic                   in;
  logic                   enable;
  logic                   clear;
  logic                   match;
  logic                   rise;
  logic                   fall;
  logic [COUNT_WIDTH-1:0] match_count;
  logic                   overflow;

  modport master (
    output in, enable, clear,
    input  match, rise, fall, match_count, overflow
  );

  modport slave (
    input  in, enable, clear,
    output match, rise, fall, match_count, overflow
  );
endinterface

// File: rtl/pass_monitor.sv
// Serial pattern/edge monitor: overlapping pattern match, saturating match counter, sticky overflow.
// One-cycle registered latency from the sampling edge; no backpressure, enable=0 just skips a sample.
module pass_monitor #(
  parameter int                       PATTERN_WIDTH = 4,
  parameter logic [PATTERN_WIDTH-1:0] PATTERN       = 4'b1011,
  parameter int                       COUNT_WIDTH   = 8
) (
  input logic           clock,
  input logic           reset,
  pass_monitor_if.slave bus
);

  localparam int FILL_WIDTH = $clog2(PATTERN_WIDTH + 1);
  localparam logic [FILL_WIDTH-1:0]  FILL_FULL = FILL_WIDTH'(PATTERN_WIDTH);
  localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = {COUNT_WIDTH{1'b1}};

  logic [PATTERN_WIDTH-1:0] window;
  logic [FILL_WIDTH-1:0]    fill;
  logic                     prev;
  logic                     prev_valid;

  logic [PATTERN_WIDTH-1:0] window_next;
  logic [FILL_WIDTH-1:0]    fill_next;
  logic                     hit;

  always_comb begin
    window_next = {window[PATTERN_WIDTH-2:0], bus.in};
    fill_next   = (fill == FILL_FULL) ? fill : fill + 1'b1;
    // A partially filled window must never match, even for an all-zero pattern.
    hit         = (window_next == PATTERN) && (fill_next == FILL_FULL);
  end

  always_ff @(posedge clock) begin
    if (reset || bus.clear) begin
      window          <= '0;
      fill            <= '0;
      prev            <= 1'b0;
      prev_valid      <= 1'b0;
      bus.match       <= 1'b0;
      bus.rise        <= 1'b0;
      bus.fall        <= 1'b0;
      bus.match_count <= '0;
      bus.overflow    <= 1'b0;
    end else if (bus.enable) begin
      window     <= window_next;
      fill       <= fill_next;
      prev       <= bus.in;
      prev_valid <= 1'b1;
      bus.match  <= hit;
      bus.rise   <= prev_valid & ~prev & bus.in;
      bus.fall   <= prev_valid & prev & ~bus.in;
      if (hit) begin
        if (bus.match_count == COUNT_MAX) begin
          bus.overflow <= 1'b1;
        end else begin
          bus.match_count <= bus.match_count + 1'b1;
        end
      end
    end else begin
      bus.match <= 1'b0;
      bus.rise  <= 1'b0;
      bus.fall  <= 1'b0;
    end
  end

endmodule
